// File: rtl/hamming_enc_sched_if.sv
// hamming_enc_sched_if: requester, encoder and downstream signals of hamming_enc_sched.
// Latency: none, wires only.
// Backpressure: carries req_valid/req_ready and out_valid/out_ready; the scheduler owns the flow control.
// Modports: slave = scheduler view, master = environment view (requesters, encoder, sink).
interface hamming_enc_sched_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        enc_start;
  logic [7:0]  enc_din;
  logic [10:0] enc_dout;
  logic        out_valid;
  logic [10:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        busy;
  logic        err;
  logic [15:0] pkt_cnt;

  modport slave (
    input  req_valid, req_data, enc_dout, out_ready,
    output req_ready, enc_start, enc_din, out_valid, out_data, out_src, busy, err, pkt_cnt
  );

  modport master (
    output req_valid, req_data, enc_dout, out_ready,
    input  req_ready, enc_start, enc_din, out_valid, out_data, out_src, busy, err, pkt_cnt
  );
endinterface

// File: rtl/hamming_enc_sched.sv
// hamming_enc_sched: round-robin scheduler sharing one 8b->11b encoder among four requesters.
// Latency: grant at edge E -> out_valid after edge E+ENC_LAT; one word in flight at a time.
// Backpressure: out_ready low holds OUT with data/src stable and blocks every new grant.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries req_valid/req_data/req_ready,
//        enc_start/enc_din/enc_dout, out_valid/out_data/out_src/out_ready, busy, err, pkt_cnt.
module hamming_enc_sched #(
  parameter int N_REQ   = 4,
  parameter int ENC_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  hamming_enc_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

  state_t      state_q;
  logic [1:0]  rr_q;
  logic [1:0]  gnt_q;
  logic [3:0]  lat_q;
  logic        enc_start_q;
  logic [7:0]  enc_din_q;
  logic        out_valid_q;
  logic [10:0] out_data_q;
  logic [1:0]  out_src_q;
  logic        busy_q;
  logic        err_q;
  logic [15:0] pkt_cnt_q;

  logic        gnt_vld_d;
  logic [1:0]  gnt_idx_d;
  logic [1:0]  rr_cand;

  // First valid requester at or above rr_q, wrapping modulo 4.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_idx_d = 2'd0;
    rr_cand   = 2'd0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_cand = rr_q + 2'(k);
      if (!gnt_vld_d && bus.req_valid[rr_cand]) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = rr_cand;
      end
    end
  end

  // Systematic positions hold the data bits; parity bits are recomputed from the
  // received word itself, so a corrupted parity or data bit both show up here.
  function automatic logic enc_bad(input logic [7:0] din, input logic [10:0] dout);
    return (dout[3:0] != din[3:0]) ||
           (dout[6] != din[4]) || (dout[8] != din[5]) ||
           (dout[9] != din[6]) || (dout[10] != din[7]) ||
           (dout[4] != (dout[6] ^ dout[8] ^ dout[10])) ||
           (dout[5] != (dout[6] ^ dout[9] ^ dout[10])) ||
           (dout[7] != (dout[8] ^ dout[9] ^ dout[10]));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 2'd0;
      gnt_q       <= 2'd0;
      lat_q       <= 4'd0;
      enc_start_q <= 1'b0;
      enc_din_q   <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 11'd0;
      out_src_q   <= 2'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= 16'd0;
    end else begin
      enc_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            state_q     <= ENC;
            gnt_q       <= gnt_idx_d;
            enc_din_q   <= bus.req_data[{gnt_idx_d, 3'b000} +: 8];
            lat_q       <= 4'(ENC_LAT);
            enc_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ENC: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q == 4'd1) begin
            state_q     <= OUT;
            out_data_q  <= bus.enc_dout;
            out_src_q   <= gnt_q;
            out_valid_q <= 1'b1;
            if (enc_bad(enc_din_q, bus.enc_dout)) begin
              err_q <= 1'b1;
            end
          end
        end
        OUT: begin
          // No grant in the handshake cycle: the next search starts from IDLE.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_q        <= gnt_q + 2'd1;
            pkt_cnt_q   <= pkt_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational accept; rst_n gating keeps it low while reset is held.
  assign bus.req_ready = (rst_n && state_q == IDLE && gnt_vld_d) ? (4'b0001 << gnt_idx_d) : 4'b0000;
  assign bus.enc_start = enc_start_q;
  assign bus.enc_din   = enc_din_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.pkt_cnt   = pkt_cnt_q;

endmodule
